spi_xfer_ctrl: RTL and testbench

//  Sequences one SPI byte transfer on the MSX cartridge SPI port. Generates SCLK, shifts MOSI and samples MISO.

---
 rtl/spi_xfer_ctrl.sv | 177 +++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - SPI single-byte transfer sequencer; optional CPHA support under SPI_CPHA_EN
module spi_xfer_ctrl #(
    parameter int DATA_W  = 8,
    parameter int SPEED_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               cpol,
`ifdef SPI_CPHA_EN
    input  logic               cpha,
`endif
    input  logic [SPEED_W-1:0] speed,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic               ss_n,
    output logic [DATA_W-1:0]  rx_data,
    output logic               busy,
    output logic               done
);
    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HALF,
        ST_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [SPEED_W-1:0]  div_q, div_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                ss_n_q, ss_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cpha_in;
    logic [EDGE_W-1:0]   edge_nxt;
    logic                leading;

`ifdef SPI_CPHA_EN
    assign cpha_in = cpha;
`else
    assign cpha_in = 1'b0;
`endif

    // State and output registers; reset aborts any transfer in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            speed_q <= '0;
            edge_q  <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            speed_q <= speed_d;
            edge_q  <= edge_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ss_n_q  <= ss_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: divider, edge counting, shifting and sampling per phase mode
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        speed_d  = speed_q;
        edge_d   = edge_q;
        shift_d  = shift_q;
        rx_d     = rx_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        ss_n_d   = ss_n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        edge_nxt = edge_q + 1'b1;
        leading  = edge_nxt[0];

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol;
                // a start arriving while done is still showing is dropped
                if (start && !done_q) begin
                    state_d = ST_LOAD;
                    shift_d = tx_data;
                    speed_d = speed;
                    cpol_d  = cpol;
                    cpha_d  = cpha_in;
                end
            end
            ST_LOAD: begin
                busy_d  = 1'b1;
                ss_n_d  = 1'b0;
                sclk_d  = cpol_q;
                div_d   = '0;
                edge_d  = '0;
                if (!cpha_q) begin
                    mosi_d = shift_q[DATA_W-1];
                end
                state_d = ST_HALF;
            end
            ST_HALF: begin
                if (div_q == speed_q) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
                    if (!cpha_q) begin
                        if (leading) begin
                            shift_d = {shift_q[DATA_W-2:0], miso};
                        end else if (edge_nxt != LAST_EDGE) begin
                            mosi_d = shift_q[DATA_W-1];
                        end
                    end else begin
                        if (leading) begin
                            mosi_d  = shift_q[DATA_W-1];
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        end else begin
                            shift_d = {shift_q[DATA_W-1:1], miso};
                        end
                    end
                    if (edge_nxt == LAST_EDGE) begin
                        state_d = ST_FIN;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_FIN: begin
                rx_d    = shift_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ss_n_d  = 1'b1;
                sclk_d  = cpol_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;
    assign rx_data = rx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - randomized self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  tx_data;
    logic          cpol;
`ifdef SPI_CPHA_EN
    logic          cpha;
`endif
    logic [SW-1:0] speed;
    logic          miso;
    logic          miso_r;
    logic          loop_en;
    logic          sclk, mosi, ss_n, busy, done;
    logic [W-1:0]  rx_data;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [W-1:0]  prev_rx;
    logic          mosi_prev;

    assign miso = loop_en ? mosi : miso_r;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.DATA_W(W), .SPEED_W(SW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .cpol    (cpol),
`ifdef SPI_CPHA_EN
        .cpha    (cpha),
`endif
        .speed   (speed),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .ss_n    (ss_n),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sclk"}, 32'(sclk), 32'(1'b0));
        check({tag, "_mosi"}, 32'(mosi), 32'(1'b0));
        check({tag, "_ss_n"}, 32'(ss_n), 32'(1'b1));
        check({tag, "_busy"}, 32'(busy), 32'(1'b0));
        check({tag, "_done"}, 32'(done), 32'(1'b0));
        check({tag, "_rx"},   32'(rx_data), 32'(0));
    endtask

    // mode: 0 random miso, 1 loopback, 2 miso tied high
    task automatic run_xfer(input logic [W-1:0] tx, input int spd, input logic pol, input logic ph,
                            input int mode, input int abort_k, input bit poke);
        int       h, d, k, kk, t, l, bi;
        logic     em, es, drv, aborted;
        logic [W-1:0] exp_rx;
        h       = spd + 1;
        d       = 2 + 2 * W * h;
        exp_rx  = '0;
        aborted = 1'b0;
        em      = mosi_prev;
        tx_data = tx;
        speed   = SW'(spd);
        cpol    = pol;
        loop_en = (mode == 1);
`ifdef SPI_CPHA_EN
        cpha    = ph;
`endif
        miso_r  = (mode == 2) ? 1'b1 : 1'($urandom);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        for (int n = 1; n <= d + 2 && !aborted; n++) begin
            drv    = (mode == 2) ? 1'b1 : 1'($urandom);
            miso_r = drv;
            if (poke && n == d / 2) begin
                start   = 1'b1;
                tx_data = 8'h3C;
                speed   = '0;
                cpol    = ~pol;
            end
            if (poke && n == d + 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;

            k = (n <= 1) ? 0 : (((n - 1) / h > 2 * W) ? 2 * W : (n - 1) / h);
            if (n > 1 && (n - 1) % h == 0) begin
                kk = (n - 1) / h;
                if (kk >= 1 && kk <= 2 * W && (kk % 2) == (ph ? 0 : 1)) begin
                    bi = W - 1 - (kk - 1) / 2;
                    exp_rx[bi] = (mode == 1) ? tx[bi] : drv;
                end
            end
            if (!ph) begin
                t  = (k / 2 > W - 1) ? W - 1 : k / 2;
                em = tx[W-1-t];
            end else begin
                l  = (k + 1) / 2;
                em = (l == 0) ? mosi_prev : tx[W-l];
            end
            es = (n <= d) ? (pol ^ (k % 2 == 1)) : cpol;

            check($sformatf("sclk_n%0d", n), 32'(sclk), 32'(es));
            check($sformatf("mosi_n%0d", n), 32'(mosi), 32'(em));
            check($sformatf("busy_n%0d", n), 32'(busy), 32'(n <= d - 1));
            check($sformatf("ss_n_n%0d", n), 32'(ss_n), 32'(!(n <= d - 1)));
            check($sformatf("done_n%0d", n), 32'(done), 32'(n == d));
            check($sformatf("rx_n%0d", n), 32'(rx_data), 32'((n >= d) ? exp_rx : prev_rx));

            if (abort_k > 0 && (n - 1) == abort_k * h) begin
                reset = 1'b1;
                #1;
                check_reset_vals("abort");
                #2;
                reset     = 1'b0;
                prev_rx   = '0;
                mosi_prev = 1'b0;
                aborted   = 1'b1;
                for (int m = 0; m < d; m++) begin
                    @(posedge clk); #1;
                    check("abort_done", 32'(done), 32'(1'b0));
                    check("abort_busy", 32'(busy), 32'(1'b0));
                    check("abort_sclk", 32'(sclk), 32'(cpol));
                end
            end
        end
        if (!aborted) begin
            prev_rx   = exp_rx;
            mosi_prev = em;
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        cpol    = 1'b1;
        speed   = '0;
        tx_data = '0;
        miso_r  = 1'b0;
        loop_en = 1'b0;
`ifdef SPI_CPHA_EN
        cpha    = 1'b0;
`endif
        prev_rx   = '0;
        mosi_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;
        #1;
        check("rst_rel_sclk", 32'(sclk), 32'(1'b0));
        @(posedge clk); #1;
        check("rst_sclk_cpol1", 32'(sclk), 32'(1'b1));
        cpol = 1'b0;
        @(posedge clk); #1;
        check("idle_sclk_cpol0", 32'(sclk), 32'(1'b0));

        run_xfer(8'hA5, 0, 1'b0, 1'b0, 1, -1, 1'b0);
        run_xfer(8'h00, 3, 1'b1, 1'b0, 2, -1, 1'b0);
        run_xfer(8'($urandom), 2, 1'b0, 1'b0, 0, -1, 1'b1);
        run_xfer(8'h3C, 0, cpol, 1'b0, 1, -1, 1'b0);
        run_xfer(8'($urandom), 1, 1'b0, 1'b0, 0, 7, 1'b0);
        run_xfer(8'($urandom), 1, 1'b1, 1'b0, 0, -1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_xfer(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b0,
                     int'($urandom_range(0, 1)), -1, 1'b0);
        end
        run_xfer(8'($urandom), 15, 1'b0, 1'b0, 0, -1, 1'b0);
`ifdef SPI_CPHA_EN
        run_xfer(8'h81, 1, 1'b0, 1'b1, 1, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_xfer(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                     int'($urandom_range(0, 1)), -1, 1'b0);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
